// File: rtl/branch_resolve_if.sv
// EX-stage branch resolution bundle: the resolving instruction
// presented by EX and the redirect returned to fetch/ctrl.
interface branch_resolve_if;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_inst_jal_i;
    logic        ex_inst_jalr_i;
    logic        ex_inst_bxx_i;
    logic        ex_cond_true_i;
    logic        ex_prdt_taken_i;
    logic [31:0] ex_prdt_addr_i;
    logic [31:0] ex_jalr_target_i;
    logic        flush_o;
    logic [31:0] redirect_addr_o;
    logic        busy_o;

    modport master (
        output ex_valid_i, ex_pc_i,
        output ex_inst_jal_i, ex_inst_jalr_i, ex_inst_bxx_i,
        output ex_cond_true_i, ex_prdt_taken_i,
        output ex_prdt_addr_i, ex_jalr_target_i,
        input  flush_o, redirect_addr_o, busy_o
    );

    modport slave (
        input  ex_valid_i, ex_pc_i,
        input  ex_inst_jal_i, ex_inst_jalr_i, ex_inst_bxx_i,
        input  ex_cond_true_i, ex_prdt_taken_i,
        input  ex_prdt_addr_i, ex_jalr_target_i,
        output flush_o, redirect_addr_o, busy_o
    );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: checks the ID-stage static prediction,
// issues a registered redirect and squashes the wrong-path shadow.
module branch_resolve #(
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             cnt_clr_i,
    branch_resolve_if.slave  ex,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam logic [2:0] SHADOW_LD = SHADOW_CYCLES[2:0];

    typedef enum logic {
        IDLE,
        SHADOW
    } state_t;

    state_t      state;
    logic [2:0]  shadow_cnt;

    logic        is_jalr;
    logic        is_jal;
    logic        is_ctl;
    logic        act_taken;
    logic [31:0] act_target;
    logic        mispred;
    logic [31:0] redir_addr;
    logic        fire;

    // Decode the actual outcome; jalr wins over jal, jal over bxx.
    always_comb begin
        is_jalr    = ex.ex_inst_jalr_i;
        is_jal     = ex.ex_inst_jal_i & ~ex.ex_inst_jalr_i;
        is_ctl     = ex.ex_inst_jalr_i | ex.ex_inst_jal_i
                   | ex.ex_inst_bxx_i;
        act_taken  = ex.ex_cond_true_i;
        act_target = ex.ex_prdt_addr_i;
        mispred    = 1'b0;
        unique case (1'b1)
            is_jalr: begin
                act_taken  = 1'b1;
                act_target = ex.ex_jalr_target_i & ~32'h1;
                mispred    = 1'b1;
            end
            is_jal: begin
                act_taken = 1'b1;
                mispred   = ~ex.ex_prdt_taken_i;
            end
            default: begin
                mispred = act_taken ^ ex.ex_prdt_taken_i;
            end
        endcase
        redir_addr = act_taken ? act_target : ex.ex_pc_i + 32'd4;
        fire = ex.ex_valid_i & ~hold_i & (state == IDLE) & is_ctl;
    end

    // Redirect/shadow FSM; outputs are registered so flush is one cycle late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            shadow_cnt         <= 3'd0;
            ex.flush_o         <= 1'b0;
            ex.redirect_addr_o <= 32'd0;
            ex.busy_o          <= 1'b0;
        end else begin
            ex.flush_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fire && mispred) begin
                        state              <= SHADOW;
                        shadow_cnt         <= SHADOW_LD;
                        ex.flush_o         <= 1'b1;
                        ex.redirect_addr_o <= redir_addr;
                        ex.busy_o          <= 1'b1;
                    end
                end
                SHADOW: begin
                    shadow_cnt <= shadow_cnt - 3'd1;
                    if (shadow_cnt == 3'd1) begin
                        state     <= IDLE;
                        ex.busy_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (fire) begin
            if (branch_cnt_o != '1)
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (mispred && mispredict_cnt_o != '1)
                mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage counterpart of the static branch predictor.
- Resolves jal/jalr/bxx in EX and compares the actual outcome against the prediction carried down from ID (prdt_taken, prdt_addr).
- On mismatch, issues a registered one-cycle flush with the corrected fetch address, then squashes wrong-path instructions for a fixed shadow window.
- Keeps saturating branch and mispredict counters for performance CSRs.

Parameters:
- SHADOW_CYCLES, 2, cycles after flush_o during which ex_valid_i is ignored (wrong-path instructions). Legal range 1..7.
- CNT_W, 32, width of the branch and mispredict counters.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-low reset
- hold_i  input  1  pipeline stall; when 1, the EX instruction is not resolved this cycle
- ex_valid_i  input  1  EX holds a valid instruction
- ex_pc_i  input  32  PC of the EX instruction
- ex_inst_jal_i  input  1  EX instruction is jal
- ex_inst_jalr_i  input  1  EX instruction is jalr
- ex_inst_bxx_i  input  1  EX instruction is a conditional branch
- ex_cond_true_i  input  1  branch comparison result (meaningful only for bxx)
- ex_prdt_taken_i  input  1  prediction made in ID
- ex_prdt_addr_i  input  32  predicted target (pc+imm) made in ID
- ex_jalr_target_i  input  32  rs1+imm computed in EX
- cnt_clr_i  input  1  synchronous clear of both counters
- flush_o  output  1  one-cycle redirect request to fetch/ctrl
- redirect_addr_o  output  32  corrected fetch address, valid when flush_o=1
- busy_o  output  1  1 while in SHADOW state
- branch_cnt_o  output  CNT_W  resolved control-transfer count
- mispredict_cnt_o  output  CNT_W  mispredict count

Behaviour:
- Reset (rst=0, async): flush_o=0, redirect_addr_o=0, busy_o=0, both counters=0, state=IDLE, shadow counter=0.
- A resolve event is `fire = ex_valid_i & ~hold_i & state==IDLE & (jal|jalr|bxx)`.
- Actual outcome:
  - jal: taken, target = ex_prdt_addr_i.
  - jalr: taken, target = ex_jalr_target_i & ~32'h1.
  - bxx: taken = ex_cond_true_i, target = ex_prdt_addr_i.
- Mispredict condition:
  - jalr: always a mispredict (no jalr prediction exists).
  - jal/bxx: mispredict iff actual taken != ex_prdt_taken_i.
- Redirect address:
  - Actual taken: the actual target.
  - Predicted taken but actually not taken: ex_pc_i + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Latency: for a mispredicting fire in cycle N, flush_o=1 and redirect_addr_o are valid in cycle N+1 only (registered). flush_o is never high two consecutive cycles.
- redirect_addr_o holds its last value while flush_o=0.
- FSM:
  - IDLE: on mispredicting fire, go to SHADOW and load shadow counter = SHADOW_CYCLES. Otherwise stay in IDLE.
  - SHADOW: busy_o=1; ex_valid_i is ignored (no fire, no counting); the counter decrements each cycle regardless of hold_i. When the counter reaches 1 and decrements, return to IDLE; the next cycle may fire.
  - busy_o is registered and rises together with flush_o in cycle N+1.
- Counters:
  - branch_cnt_o increments by 1 on every fire.
  - mispredict_cnt_o increments by 1 on every mispredicting fire.
  - Both saturate at all-ones (no wrap).
  - cnt_clr_i has priority over increment in the same cycle.
- Simultaneous events:
  - hold_i=1 with ex_valid_i=1: no fire; resolution is deferred to the first unstalled cycle.
  - Multiple inst flags high is illegal. Priority if it occurs: jalr > jal > bxx.
- Reset mid-SHADOW: returns to IDLE immediately, busy_o=0, any pending flush dropped.

Test Plan:
1. bxx at pc=0x100, prdt_taken=1, prdt_addr=0xF0, cond_true=1 -> no flush; branch_cnt=1, mispredict_cnt=0.
2. bxx at pc=0x200, prdt_taken=0, prdt_addr=0x240, cond_true=1 -> next cycle flush_o=1, redirect_addr=0x240; busy_o=1 for 2 cycles; mispredict_cnt=1.
3. bxx at pc=0xFFFFFFFC, prdt_taken=1, cond_true=0 -> flush_o with redirect_addr=0x00000000.
4. jalr with ex_jalr_target_i=0x1235 -> flush_o, redirect_addr=0x1234. A jal presented in the following 2 shadow cycles is not counted and raises no flush.
5. hold_i=1 for 3 cycles with a mispredicting bxx in EX -> no flush during the hold; flush_o exactly 1 cycle after hold_i drops. Also: assert rst=0 during SHADOW -> busy_o=0 immediately.
6. Preload the counters near all-ones (force), then issue 3 branches -> counters stick at 0xFFFFFFFF. cnt_clr_i=1 together with a fire -> both counters read 0 next cycle.
